// File: rtl/key_debounce_bank.sv
// rtl/key_debounce_bank.sv - multi-channel push-button synchroniser/debouncer
//
// Purpose: conditions CHANNELS raw key pins into clean pressed levels plus
// one-cycle press/release pulses. Each channel is synchronised (2 flops),
// normalised so that 1 = pressed, then qualified by a four-state FSM that
// needs DEBOUNCE_CYCLES consecutive agreeing samples before accepting a change.
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   When defined, a held key emits extra key_press pulses REPEAT_DELAY cycles
//   after the accepted press and every REPEAT_PERIOD cycles thereafter.
//
// Ports:
//   CLOCK_50    in   1         sole clock, rising edge
//   reset_n     in   1         asynchronous active-low reset
//   key_raw     in   CHANNELS  unsynchronised raw key pins
//   key_level   out  CHANNELS  debounced state, 1 = pressed
//   key_press   out  CHANNELS  one-cycle pulse per accepted press / repeat
//   key_release out  CHANNELS  one-cycle pulse per accepted release
//   key_any     out  1         OR of key_level

module key_debounce_bank #(
  parameter int CHANNELS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] key_raw,
  output logic [CHANNELS-1:0] key_level,
  output logic [CHANNELS-1:0] key_press,
  output logic [CHANNELS-1:0] key_release,
  output logic                key_any
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_RELEASED        = 2'd0;
  localparam logic [1:0] S_CONFIRM_PRESS   = 2'd1;
  localparam logic [1:0] S_PRESSED         = 2'd2;
  localparam logic [1:0] S_CONFIRM_RELEASE = 2'd3;

  // Raw pin value when the key is not pressed; synchroniser flops reset here
  // so a key held through reset is seen as a fresh press.
  localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

  if (CHANNELS < 1 || CHANNELS > 32 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_debounce_bank: illegal parameter value");
  end

  assign key_any = |key_level;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          s;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1;
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);
    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_first_q, rpt_first_d;
`endif

    // Normalised sample: 1 = pressed regardless of board polarity.
    assign s = sync2_q ^ RAW_IDLE;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_d       = rpt_q;
      rpt_first_d = rpt_first_q;
`endif
      case (state_q)
        S_RELEASED: begin
          if (s) begin
            state_d = S_CONFIRM_PRESS;
            cnt_d   = CW'(1);
          end
        end
        S_CONFIRM_PRESS: begin
          if (!s) begin
            state_d = S_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = S_PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rpt_d       = '0;
            rpt_first_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_PRESSED: begin
          if (!s) begin
            state_d = S_CONFIRM_RELEASE;
            cnt_d   = CW'(1);
          end
`ifdef KEY_AUTOREPEAT_EN
          // First interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
          if (rpt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
            press_d     = 1'b1;
            rpt_d       = '0;
            rpt_first_d = 1'b0;
          end else begin
            rpt_d = rpt_q + RW'(1);
          end
`endif
        end
        S_CONFIRM_RELEASE: begin
          // Repeat counter is frozen here; a bounce back resumes it.
          if (s) begin
            state_d = S_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d   = S_RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q   <= RAW_IDLE;
        sync2_q   <= RAW_IDLE;
        state_q   <= S_RELEASED;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_q       <= '0;
        rpt_first_q <= 1'b1;
`endif
      end else begin
        sync1_q   <= key_raw[i];
        sync2_q   <= sync1_q;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
`ifdef KEY_AUTOREPEAT_EN
        rpt_q       <= rpt_d;
        rpt_first_q <= rpt_first_d;
`endif
      end
    end

    // PRESSED and CONFIRM_RELEASE share state bit 1.
    assign key_level[i]   = state_q[1];
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// tb/tb_key_debounce_bank.sv - scoreboard bench for key_debounce_bank

module tb_key_debounce_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] raw_a, lvl_a, prs_a, rel_a;
  logic [1:0] raw_b, lvl_b, prs_b, rel_b;
  logic       any_a, any_b;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lvl;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // dut_a: active-low keys, long repeat delay so holds never auto-repeat.
  key_debounce_bank #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(1000), .REPEAT_PERIOD(5)
  ) dut_a (
    .CLOCK_50(clk), .reset_n(reset_n), .key_raw(raw_a),
    .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a), .key_any(any_a)
  );

  // dut_b: active-high keys, short repeat timing.
  key_debounce_bank #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut_b (
    .CLOCK_50(clk), .reset_n(reset_n), .key_raw(raw_b),
    .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b), .key_any(any_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic expect_ev(input int d, input int c, input logic [1:0] p,
                           input logic [1:0] r, input logic [1:0] l);
    exp_t e;
    e.cyc = c; e.prs = p; e.rel = r; e.lvl = l;
    if (d == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t qfront(input int d);
    return (d == 0) ? qa[0] : qb[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) qa.delete(0); else qb.delete(0);
  endtask

  task automatic mon(input int d, input logic [1:0] p, input logic [1:0] r,
                     input logic [1:0] l, input logic an);
    exp_t  e;
    string nm;
    nm = (d == 0) ? "a" : "b";
    while (qsize(d) > 0 && qfront(d).cyc < cyc) begin
      e = qfront(d);
      qpop(d);
      n_checks++;
      n_errors++;
      $display("FAIL missed_event_%s: no pulse at edge %0d (press %b release %b)",
               nm, e.cyc, e.prs, e.rel);
    end
    if ((p | r) != 2'b00) begin
      if (qsize(d) > 0 && qfront(d).cyc == cyc) begin
        e = qfront(d);
        qpop(d);
        chk({"press_", nm}, p, e.prs);
        chk({"release_", nm}, r, e.rel);
        chk({"level_", nm}, l, e.lvl);
        chk({"any_", nm}, {1'b0, an}, {1'b0, |e.lvl});
        chk({"press_release_excl_", nm}, p & r, 2'b00);
      end else begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse_%s at edge %0d: press %b release %b, required none",
                 nm, cyc, p, r);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, prs_a, rel_a, lvl_a, any_a);
    mon(1, prs_b, rel_b, lvl_b, any_b);
  end

  task automatic at_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    raw_a   = 2'b11;
    raw_b   = 2'b00;

    at_edge(2);
    #3;
    chk("reset_level_a", lvl_a, 2'b00);
    chk("reset_press_a", prs_a, 2'b00);
    chk("reset_release_a", rel_a, 2'b00);
    chk("reset_any_a", {1'b0, any_a}, 2'b00);
    chk("reset_level_b", lvl_b, 2'b00);
    chk("reset_press_b", prs_b, 2'b00);
    chk("reset_release_b", rel_b, 2'b00);
    chk("reset_any_b", {1'b0, any_b}, 2'b00);
    at_edge(3);
    reset_n = 1'b1;

    // Basic press/release latency (2 + DEBOUNCE_CYCLES).
    at_edge(10); raw_a[0] = 1'b0; expect_ev(0, 16, 2'b01, 2'b00, 2'b01);
    at_edge(20); chk("level_held_a", lvl_a, 2'b01);
    at_edge(30); raw_a[0] = 1'b1; expect_ev(0, 36, 2'b00, 2'b01, 2'b00);
    at_edge(40); chk("level_released_a", lvl_a, 2'b00);

    // Bouncing press: 3-cycle runs, then held.
    for (int i = 0; i < 5; i++) begin
      at_edge(50 + 3 * i);
      raw_a[0] = (i % 2 == 1);
    end
    expect_ev(0, 68, 2'b01, 2'b00, 2'b01);

    // Short release glitch while pressed: no events.
    at_edge(80); raw_a[0] = 1'b1;
    at_edge(83); raw_a[0] = 1'b0;
    at_edge(95); chk("level_after_glitch_a", lvl_a, 2'b01);
    at_edge(100); raw_a[0] = 1'b1; expect_ev(0, 106, 2'b00, 2'b01, 2'b00);

    // Simultaneous channels.
    at_edge(120); raw_a = 2'b00;    expect_ev(0, 126, 2'b11, 2'b00, 2'b11);
    at_edge(140); raw_a[1] = 1'b1;  expect_ev(0, 146, 2'b00, 2'b10, 2'b01);
    at_edge(150); chk("any_one_held_a", {1'b0, any_a}, 2'b01);
    at_edge(160); raw_a[0] = 1'b1;  expect_ev(0, 166, 2'b00, 2'b01, 2'b00);

    // Reset during CONFIRM_PRESS at count 2, key held across release.
    at_edge(180); raw_a[0] = 1'b0;
    at_edge(184); reset_n = 1'b0;
    at_edge(186); chk("level_in_reset_a", lvl_a, 2'b00);
    at_edge(190); reset_n = 1'b1; expect_ev(0, 196, 2'b01, 2'b00, 2'b01);
    at_edge(200); chk("level_after_reheld_a", lvl_a, 2'b01);

    // Reset while pressed: immediate clear, no release pulse.
    at_edge(210); reset_n = 1'b0;
    #1;
    chk("level_async_reset_a", lvl_a, 2'b00);
    raw_a = 2'b11;
    at_edge(215); reset_n = 1'b1;
    at_edge(225); chk("level_post_reset_a", lvl_a, 2'b00);

    // Active-high polarity on channel 1.
    at_edge(240); raw_b[1] = 1'b1; expect_ev(1, 246, 2'b10, 2'b00, 2'b10);
    at_edge(250); raw_b[1] = 1'b0; expect_ev(1, 256, 2'b00, 2'b10, 2'b00);

    // Long hold: repeats only when the auto-repeat build is selected.
    at_edge(270); raw_b[0] = 1'b1; expect_ev(1, 276, 2'b01, 2'b00, 2'b01);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 0; k < 7; k++) expect_ev(1, 286 + 5 * k, 2'b01, 2'b00, 2'b01);
`endif
    at_edge(300); chk("level_long_hold_b", lvl_b, 2'b01);
    at_edge(316); raw_b[0] = 1'b0; expect_ev(1, 322, 2'b00, 2'b01, 2'b00);

    at_edge(335);
    #3;
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_errors++;
      $display("FAIL queues_drained: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
